crack_dispatch: RTL and testbench
=================================

// Module: crack_dispatch
// PURPOSE
//   Sequences NUM_CORES parallel crack cores over an interleaved 24-bit key space.
//   Core i gets key_start = base_key + i and steps by NUM_CORES; cores must be built with that stride.
//   Reports the first core to return key_valid and aborts the remaining cores through their resets.
//   Sits between the top-level en/rdy handshake and the core array.
// PARAMETERS
//   NUM_CORES   2   crack core count, 1..8; must equal the core key stride
//   RST_CYCLES  2   cycles core_rst_n is held low on launch and on abort, >=1
// PORTS
//   clk             in   1              single clock, rising edge
//   rst             in   1              asynchronous, active-high reset
//   en              in   1              start request; accepted only while rdy=1
//   rdy             out  1              1 = idle, ready to accept en
//   base_key        in   24             first key of the search; sampled on en acceptance
//   key             out  24             winning key; valid only when key_valid=1
//   key_valid       out  1              1 = last search found a key
//   cycle_count     out  32             search duration (see CONFIGURATION)
//   core_rst_n      out  1              active-low reset, common to all cores
//   core_en         out  NUM_CORES      per-core start pulse
//   core_key_start  out  24*NUM_CORES   core i at [24*i +: 24]
//   core_rdy        in   NUM_CORES      per-core rdy
//   core_key        in   24*NUM_CORES   per-core key, core i at [24*i +: 24]
//   core_key_valid  in   NUM_CORES      per-core key_valid
// BEHAVIOUR
//   Reset (async, any state): state=IDLE; rdy=1, key=0, key_valid=0, core_rst_n=0, core_en=0,
//     core_key_start=0, cycle_count=0. core_rst_n is released to 1 in the first clock after rst deasserts.
//   core_key_start[i] = base_reg + i, mod 2^24 (wraps; e.g. FFFFFF+1 = 000000).
//   FSM:
//   - IDLE: rdy=1. On en=1, latch base_reg, clear key_valid, drop rdy -> CORE_RST. en while rdy=0 is ignored.
//   - CORE_RST: core_rst_n=0 for exactly RST_CYCLES cycles -> LAUNCH.
//   - LAUNCH: core_en = all ones for 1 cycle; clear run/done masks -> RUN.
//   - RUN: run[i] is set when core_rdy[i]=0 is seen. done[i] is set when run[i]=1 and core_rdy[i]=1.
//     When core i sets done with core_key_valid[i]=1, latch core_key[i] as the winner -> ABORT.
//     If several cores win in the same cycle, the lowest index wins.
//     If done = all ones and none valid -> FINISH with key_valid=0.
//   - ABORT: core_rst_n=0 for RST_CYCLES cycles -> FINISH.
//   - FINISH: key <= winner (or 0 if none), key_valid <= found, rdy <= 1 -> IDLE.
//   Result latency: rdy rises 1 cycle after leaving ABORT (or after the last done in the no-win case).
//   key/key_valid hold until the next en is accepted.
//   core_en is never asserted outside LAUNCH.
//   core_rdy is ignored outside RUN, so pre-launch rdy=1 is not counted as done.
//   A core that never drops rdy holds RUN indefinitely; no timeout (top-level rst recovers).
// CONFIGURATION
//   CRACK_DISPATCH_PERF_EN defined:
//     cycle_count clears on en acceptance and increments every cycle while rdy=0.
//     It saturates at FFFFFFFF and holds its value after rdy rises.
//   CRACK_DISPATCH_PERF_EN undefined: cycle_count tied to 0; no counter logic.
// TESTING
//   1. Reset mid-RUN: assert rst -> same cycle rdy=1, key_valid=0, core_en=0, core_rst_n=0.
//   2. NUM_CORES=2, base_key=000000: en -> core_key_start = 000000/000001; core_rst_n low 2 cycles; then core_en=11 for 1 cycle.
//   3. Core 1 finishes valid with key=00A3F1, core 0 still busy -> ABORT 2 cycles, then key=00A3F1, key_valid=1, rdy=1.
//   4. Both cores finish valid in the same cycle (keys 000010, 000011) -> key=000010.
//   5. Both cores finish invalid -> key_valid=0, key=0, rdy=1; core_rst_n never pulsed after launch.
//   6. base_key=FFFFFF -> core_key_start[1]=000000. en pulsed while rdy=0 -> no restart.
//      PERF_EN: cycle_count equals the cycles with rdy=0.

Source files
------------

// File: rtl/crack_dispatch.sv
// rtl/crack_dispatch.sv - dispatches NUM_CORES interleaved crack cores and reports the first winner
// Optional cycle counter: define CRACK_DISPATCH_PERF_EN.
module crack_dispatch #(
    parameter int NUM_CORES  = 2,
    parameter int RST_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    output logic                      rdy,
    input  logic [23:0]               base_key,
    output logic [23:0]               key,
    output logic                      key_valid,
    output logic [31:0]               cycle_count,
    output logic                      core_rst_n,
    output logic [NUM_CORES-1:0]      core_en,
    output logic [24*NUM_CORES-1:0]   core_key_start,
    input  logic [NUM_CORES-1:0]      core_rdy,
    input  logic [24*NUM_CORES-1:0]   core_key,
    input  logic [NUM_CORES-1:0]      core_key_valid
);

    typedef enum logic [2:0] {IDLE, CORE_RST, LAUNCH, RUN, ABORT, FINISH} state_t;

    state_t                    state_q, state_d;
    logic [31:0]               rst_cnt_q, rst_cnt_d;
    logic                      rdy_q, rdy_d;
    logic [23:0]               key_q, key_d;
    logic                      key_valid_q, key_valid_d;
    logic [24*NUM_CORES-1:0]   key_start_q, key_start_d;
    logic [NUM_CORES-1:0]      run_q, run_d;
    logic [NUM_CORES-1:0]      done_q, done_d;
    logic [23:0]               win_key_q, win_key_d;
    logic                      found_q, found_d;
    logic                      core_rst_n_q, core_rst_n_d;
    logic                      win;
    logic [23:0]               win_key_sel;

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        rdy_d       = rdy_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        key_start_d = key_start_q;
        run_d       = run_q;
        done_d      = done_q;
        win_key_d   = win_key_q;
        found_d     = found_q;
        win         = 1'b0;
        win_key_sel = 24'h0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    for (int i = 0; i < NUM_CORES; i++)
                        key_start_d[24*i +: 24] = base_key + 24'(i);
                    key_valid_d = 1'b0;
                    rdy_d       = 1'b0;
                    rst_cnt_d   = 32'd0;
                    state_d     = CORE_RST;
                end
            end
            CORE_RST: begin
                if (rst_cnt_q == 32'(RST_CYCLES - 1)) begin
                    rst_cnt_d = 32'd0;
                    state_d   = LAUNCH;
                end else begin
                    rst_cnt_d = rst_cnt_q + 32'd1;
                end
            end
            LAUNCH: begin
                run_d     = '0;
                done_d    = '0;
                found_d   = 1'b0;
                win_key_d = 24'h0;
                state_d   = RUN;
            end
            RUN: begin
                // Descending scan so the lowest-index simultaneous winner is kept.
                for (int i = NUM_CORES - 1; i >= 0; i--) begin
                    if (!run_q[i] && !core_rdy[i])
                        run_d[i] = 1'b1;
                    if (run_q[i] && core_rdy[i] && !done_q[i]) begin
                        done_d[i] = 1'b1;
                        if (core_key_valid[i]) begin
                            win         = 1'b1;
                            win_key_sel = core_key[24*i +: 24];
                        end
                    end
                end
                if (win) begin
                    win_key_d = win_key_sel;
                    found_d   = 1'b1;
                    rst_cnt_d = 32'd0;
                    state_d   = ABORT;
                end else if (&done_d) begin
                    state_d = FINISH;
                end
            end
            ABORT: begin
                if (rst_cnt_q == 32'(RST_CYCLES - 1)) begin
                    rst_cnt_d = 32'd0;
                    state_d   = FINISH;
                end else begin
                    rst_cnt_d = rst_cnt_q + 32'd1;
                end
            end
            FINISH: begin
                key_d       = found_q ? win_key_q : 24'h0;
                key_valid_d = found_q;
                rdy_d       = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        core_rst_n_d = !(state_d == CORE_RST || state_d == ABORT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rst_cnt_q    <= 32'd0;
            rdy_q        <= 1'b1;
            key_q        <= 24'h0;
            key_valid_q  <= 1'b0;
            key_start_q  <= '0;
            run_q        <= '0;
            done_q       <= '0;
            win_key_q    <= 24'h0;
            found_q      <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            rdy_q        <= rdy_d;
            key_q        <= key_d;
            key_valid_q  <= key_valid_d;
            key_start_q  <= key_start_d;
            run_q        <= run_d;
            done_q       <= done_d;
            win_key_q    <= win_key_d;
            found_q      <= found_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

`ifdef CRACK_DISPATCH_PERF_EN
    logic [31:0] cycle_count_q, cycle_count_d;

    always_comb begin
        cycle_count_d = cycle_count_q;
        if (state_q == IDLE && en)
            cycle_count_d = 32'd0;
        else if (!rdy_q && cycle_count_q != 32'hFFFF_FFFF)
            cycle_count_d = cycle_count_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cycle_count_q <= 32'd0;
        else
            cycle_count_q <= cycle_count_d;
    end

    assign cycle_count = cycle_count_q;
`else
    assign cycle_count = 32'd0;
`endif

    assign rdy            = rdy_q;
    assign key            = key_q;
    assign key_valid      = key_valid_q;
    assign core_rst_n     = core_rst_n_q;
    assign core_key_start = key_start_q;
    assign core_en        = (state_q == LAUNCH) ? {NUM_CORES{1'b1}} : {NUM_CORES{1'b0}};

endmodule

// File: tb/tb_crack_dispatch.sv
// tb/tb_crack_dispatch.sv - directed self-checking bench for crack_dispatch (NUM_CORES=2, RST_CYCLES=2)
module tb_crack_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        rdy;
    logic [23:0] base_key;
    logic [23:0] key;
    logic        key_valid;
    logic [31:0] cycle_count;
    logic        core_rst_n;
    logic [1:0]  core_en;
    logic [47:0] core_key_start;
    logic [1:0]  core_rdy;
    logic [47:0] core_key;
    logic [1:0]  core_key_valid;

    int checks = 0;
    int failures = 0;

    crack_dispatch #(.NUM_CORES(2), .RST_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .en(en), .rdy(rdy), .base_key(base_key),
        .key(key), .key_valid(key_valid), .cycle_count(cycle_count),
        .core_rst_n(core_rst_n), .core_en(core_en), .core_key_start(core_key_start),
        .core_rdy(core_rdy), .core_key(core_key), .core_key_valid(core_key_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accepts en and advances to the LAUNCH cycle.
    task automatic launch(input logic [23:0] b);
        base_key = b;
        en = 1'b1;
        step();
        en = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; base_key = 24'h0;
        core_rdy = 2'b11; core_key = 48'h0; core_key_valid = 2'b00;
        step();
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy got=%b exp=1", rdy); end
        checks++; if (key !== 24'h0 || key_valid !== 1'b0) begin failures++; $display("FAIL reset_key got=%h/%b exp=000000/0", key, key_valid); end
        checks++; if (core_rst_n !== 1'b0 || core_en !== 2'b00) begin failures++; $display("FAIL reset_core got=%b/%b exp=0/00", core_rst_n, core_en); end
        checks++; if (core_key_start !== 48'h0 || cycle_count !== 32'h0) begin failures++; $display("FAIL reset_start got=%h/%h exp=0/0", core_key_start, cycle_count); end
        rst = 1'b0;
        step();
        checks++; if (core_rst_n !== 1'b1) begin failures++; $display("FAIL reset_release got=%b exp=1", core_rst_n); end
    endtask

    task automatic test_launch_and_win();
        base_key = 24'h000000;
        en = 1'b1;
        step();
        en = 1'b0;
        checks++; if (rdy !== 1'b0 || core_rst_n !== 1'b0) begin failures++; $display("FAIL launch_rst1 got=%b/%b exp=0/0", rdy, core_rst_n); end
        checks++; if (core_key_start !== {24'h000001, 24'h000000}) begin failures++; $display("FAIL launch_start got=%h exp=000001000000", core_key_start); end
        checks++; if (core_en !== 2'b00) begin failures++; $display("FAIL launch_en_early got=%b exp=00", core_en); end
        step();
        checks++; if (core_rst_n !== 1'b0) begin failures++; $display("FAIL launch_rst2 got=%b exp=0", core_rst_n); end
        step();
        checks++; if (core_rst_n !== 1'b1 || core_en !== 2'b11) begin failures++; $display("FAIL launch_pulse got=%b/%b exp=1/11", core_rst_n, core_en); end
        core_rdy = 2'b00;
        step();
        checks++; if (core_en !== 2'b00) begin failures++; $display("FAIL launch_en_one got=%b exp=00", core_en); end
        step();
        core_rdy = 2'b10; core_key = {24'h00A3F1, 24'h0}; core_key_valid = 2'b10;
        step();
        core_rdy = 2'b11; core_key_valid = 2'b00;
        checks++; if (core_rst_n !== 1'b0 || rdy !== 1'b0) begin failures++; $display("FAIL abort1 got=%b/%b exp=0/0", core_rst_n, rdy); end
        step();
        checks++; if (core_rst_n !== 1'b0) begin failures++; $display("FAIL abort2 got=%b exp=0", core_rst_n); end
        step();
        checks++; if (core_rst_n !== 1'b1 || rdy !== 1'b0) begin failures++; $display("FAIL finish got=%b/%b exp=1/0", core_rst_n, rdy); end
        step();
        checks++; if (rdy !== 1'b1 || key !== 24'h00A3F1 || key_valid !== 1'b1) begin failures++; $display("FAIL win_result got=%b/%h/%b exp=1/00a3f1/1", rdy, key, key_valid); end
`ifdef CRACK_DISPATCH_PERF_EN
        checks++; if (cycle_count !== 32'd8) begin failures++; $display("FAIL perf_count got=%0d exp=8", cycle_count); end
`else
        checks++; if (cycle_count !== 32'd0) begin failures++; $display("FAIL perf_tied got=%0d exp=0", cycle_count); end
`endif
        step();
        checks++; if (key !== 24'h00A3F1 || key_valid !== 1'b1) begin failures++; $display("FAIL win_hold got=%h/%b exp=00a3f1/1", key, key_valid); end
    endtask

    task automatic test_tie();
        launch(24'h000010);
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL tie_clear got=%b exp=0", key_valid); end
        core_rdy = 2'b00;
        step();
        step();
        core_rdy = 2'b11; core_key = {24'h000011, 24'h000010}; core_key_valid = 2'b11;
        step();
        core_key_valid = 2'b00;
        step();
        step();
        step();
        checks++; if (rdy !== 1'b1 || key !== 24'h000010 || key_valid !== 1'b1) begin failures++; $display("FAIL tie_result got=%b/%h/%b exp=1/000010/1", rdy, key, key_valid); end
    endtask

    task automatic test_no_win();
        launch(24'h000100);
        core_rdy = 2'b00;
        step();
        step();
        core_rdy = 2'b01;
        step();
        checks++; if (rdy !== 1'b0 || core_rst_n !== 1'b1) begin failures++; $display("FAIL nowin_partial got=%b/%b exp=0/1", rdy, core_rst_n); end
        core_rdy = 2'b11;
        step();
        checks++; if (rdy !== 1'b0 || core_rst_n !== 1'b1) begin failures++; $display("FAIL nowin_finish got=%b/%b exp=0/1", rdy, core_rst_n); end
        step();
        checks++; if (rdy !== 1'b1 || key !== 24'h0 || key_valid !== 1'b0) begin failures++; $display("FAIL nowin_result got=%b/%h/%b exp=1/000000/0", rdy, key, key_valid); end
    endtask

    task automatic test_wrap_and_ignore();
        base_key = 24'hFFFFFF;
        en = 1'b1;
        step();
        checks++; if (core_key_start !== {24'h000000, 24'hFFFFFF}) begin failures++; $display("FAIL wrap_start got=%h exp=000000ffffff", core_key_start); end
        base_key = 24'h123456;
        step();
        step();
        checks++; if (core_en !== 2'b11 || core_key_start !== {24'h000000, 24'hFFFFFF}) begin failures++; $display("FAIL ignore_en got=%b/%h exp=11/000000ffffff", core_en, core_key_start); end
        core_rdy = 2'b00;
        step();
        step();
        en = 1'b0;
        core_rdy = 2'b01; core_key = {24'h0, 24'hABCDEF}; core_key_valid = 2'b01;
        step();
        core_rdy = 2'b11; core_key_valid = 2'b00;
        step();
        step();
        step();
        checks++; if (rdy !== 1'b1 || key !== 24'hABCDEF || key_valid !== 1'b1) begin failures++; $display("FAIL wrap_result got=%b/%h/%b exp=1/abcdef/1", rdy, key, key_valid); end
    endtask

    task automatic test_reset_mid_run();
        launch(24'h000200);
        core_rdy = 2'b00;
        step();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (rdy !== 1'b1 || key_valid !== 1'b0) begin failures++; $display("FAIL midrst_rdy got=%b/%b exp=1/0", rdy, key_valid); end
        checks++; if (core_en !== 2'b00 || core_rst_n !== 1'b0) begin failures++; $display("FAIL midrst_core got=%b/%b exp=00/0", core_en, core_rst_n); end
        checks++; if (core_key_start !== 48'h0 || cycle_count !== 32'h0) begin failures++; $display("FAIL midrst_start got=%h/%h exp=0/0", core_key_start, cycle_count); end
        core_rdy = 2'b11;
        step();
        rst = 1'b0;
        step();
        checks++; if (core_rst_n !== 1'b1 || rdy !== 1'b1) begin failures++; $display("FAIL midrst_release got=%b/%b exp=1/1", core_rst_n, rdy); end
    endtask

    initial begin
        test_reset();
        test_launch_and_win();
        test_tie();
        test_no_win();
        test_wrap_and_ignore();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
